// File: rtl/fib_filter_gen_pkg.sv
// Shared types and helpers for the Fibonacci stream generator.
package fib_gen_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] MODE_ALL  = 2'd0;
  localparam logic [1:0] MODE_EVEN = 2'd1;
  localparam logic [1:0] MODE_ODD  = 2'd2;

  // Mode 3 behaves like MODE_ALL.
  function automatic logic mode_pass(input logic [1:0] mode, input logic lsb);
    case (mode)
      MODE_EVEN: return !lsb;
      MODE_ODD:  return lsb;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fib_filter_gen_if.sv
// Start/done framing plus ready/valid output stream of the Fibonacci generator.
interface fib_filter_gen_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDX_WIDTH = 8
);
  logic                 __start;
  logic [WIDTH-1:0]     n;
  logic [1:0]           mode;
  logic                 __ready;
  logic                 __valid;
  logic [WIDTH-1:0]     __output_0;
  logic [IDX_WIDTH-1:0] __output_1;
  logic                 __done;
  logic                 __overflow;

  modport master (
    input  __start, n, mode, __ready,
    output __valid, __output_0, __output_1, __done, __overflow
  );

  modport slave (
    output __start, n, mode, __ready,
    input  __valid, __output_0, __output_1, __done, __overflow
  );
endinterface

// File: rtl/fib_filter_gen_step.sv
// One Fibonacci step: a+b with carry-out, and the parity filter decision on a.
module fib_step
  import fib_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             pass
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
  assign pass         = mode_pass(mode, a[0]);
endmodule

// File: rtl/fib_filter_gen.sv
// Fibonacci term generator: filtered terms with index on a ready/valid stream,
// start/done framing and sticky word-overflow detection.
module fib_filter_gen
  import fib_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDX_WIDTH = 8
) (
  input  logic             __clock,
  input  logic             __reset_n,
  fib_filter_gen_if.master bus
);
  state_t               state;
  logic [WIDTH-1:0]     a, b, n_lat, sum;
  logic                 a_carry, b_carry, carry, pass;
  logic [1:0]           mode_lat;
  logic [IDX_WIDTH-1:0] idx;
  logic                 valid, done, ovf;
  logic [WIDTH-1:0]     out_term;
  logic [IDX_WIDTH-1:0] out_idx;
  logic                 slot_free;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a     (a),
    .b     (b),
    .mode  (mode_lat),
    .sum   (sum),
    .carry (carry),
    .pass  (pass)
  );

  assign slot_free = bus.__ready || !valid;

  always_ff @(posedge __clock or negedge __reset_n) begin
    if (!__reset_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      a_carry  <= 1'b0;
      b_carry  <= 1'b0;
      idx      <= '0;
      n_lat    <= '0;
      mode_lat <= '0;
      valid    <= 1'b0;
      out_term <= '0;
      out_idx  <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // The done cycle already sits in IDLE; a start seen alongside done is dropped.
          if (bus.__start && !done) begin
            n_lat    <= bus.n;
            mode_lat <= bus.mode;
            a        <= '0;
            b        <= {{(WIDTH-1){1'b0}}, 1'b1};
            a_carry  <= 1'b0;
            b_carry  <= 1'b0;
            idx      <= '0;
            ovf      <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (slot_free) begin
            if (a_carry) begin
              valid <= 1'b0;
              ovf   <= 1'b1;
              state <= DONE;
            end else if (a >= n_lat) begin
              valid <= 1'b0;
              state <= DONE;
            end else begin
              valid <= pass;
              if (pass) begin
                out_term <= a;
                out_idx  <= idx;
              end
              a       <= b;
              a_carry <= b_carry;
              b       <= sum;
              b_carry <= b_carry | carry;
              idx     <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (slot_free) begin
            valid <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.__valid    = valid;
  assign bus.__output_0 = out_term;
  assign bus.__output_1 = out_idx;
  assign bus.__done     = done;
  assign bus.__overflow = ovf;
endmodule

// File: tb/tb_fib_filter_gen.sv
// Randomized bench for fib_filter_gen (WIDTH=32 and WIDTH=8 instances) against a Fibonacci model.
module tb_fib_filter_gen;
  import fib_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fib_filter_gen_if #(.WIDTH(32), .IDX_WIDTH(8)) i32 ();
  fib_filter_gen_if #(.WIDTH(8),  .IDX_WIDTH(8)) i8 ();

  fib_filter_gen #(.WIDTH(32), .IDX_WIDTH(8)) dut32 (
    .__clock(clk), .__reset_n(rst_n), .bus(i32.master));
  fib_filter_gen #(.WIDTH(8), .IDX_WIDTH(8)) dut8 (
    .__clock(clk), .__reset_n(rst_n), .bus(i8.master));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  longint unsigned exp_t[$];
  int unsigned     exp_i[$];
  bit              exp_ovf;
  int unsigned     exp_nterms;

  // Walk the true sequence; stop at the first term not below lim or not fitting the word.
  task automatic model(input longint unsigned lim, input int unsigned md, input int unsigned width);
    longint unsigned a = 0, b = 1, nx;
    longint unsigned top = 64'd1 << width;
    bit keep;
    exp_t.delete();
    exp_i.delete();
    exp_ovf = 1'b0;
    exp_nterms = 0;
    for (int unsigned k = 0; k < 200; k++) begin
      if (a >= top) begin exp_ovf = 1'b1; break; end
      if (a >= lim) break;
      keep = (md == 1) ? (a % 2 == 0) : (md == 2) ? (a % 2 == 1) : 1'b1;
      if (keep) begin exp_t.push_back(a); exp_i.push_back(k); end
      exp_nterms++;
      nx = a + b; a = b; b = nx;
    end
  endtask

  task automatic drive(input bit sel, input bit start, input logic [31:0] lim,
                       input logic [1:0] md, input bit rdy);
    if (sel) begin
      i8.__start = start; i8.n = lim[7:0]; i8.mode = md; i8.__ready = rdy;
    end else begin
      i32.__start = start; i32.n = lim; i32.mode = md; i32.__ready = rdy;
    end
  endtask

  task automatic sample(input bit sel, output bit v, output bit d, output bit o,
                        output logic [63:0] t, output int unsigned ix);
    if (sel) begin
      v = i8.__valid; d = i8.__done; o = i8.__overflow;
      t = 64'(i8.__output_0); ix = 32'(i8.__output_1);
    end else begin
      v = i32.__valid; d = i32.__done; o = i32.__overflow;
      t = 64'(i32.__output_0); ix = 32'(i32.__output_1);
    end
  endtask

  task automatic run(input bit sel, input logic [31:0] lim, input logic [1:0] md,
                     input bit rnd, input bit poke, input string tag);
    bit v, d, o, stalled, rdy;
    logic [63:0] t, st;
    int unsigned ix, six, first_idx;
    int first_k, done_k;
    bit had_beats;
    stalled = 1'b0; first_k = -1; done_k = -1; st = '0; six = 0;
    model(64'(lim), 32'(md), sel ? 8 : 32);
    had_beats = (exp_t.size() != 0);
    first_idx = had_beats ? exp_i[0] : 0;
    @(negedge clk);
    drive(sel, 1'b1, lim, md, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 4000; k++) begin
      if (k > 0) @(negedge clk);
      sample(sel, v, d, o, t, ix);
      if (d) begin
        done_k = k;
        check({tag, ":valid_at_done"}, 64'(v), 64'd0);
        break;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(sel, poke ? 1'($urandom_range(0, 1)) : 1'b0, lim, md, rdy);
      if (stalled) begin
        check({tag, ":stall_valid"}, 64'(v), 64'd1);
        check({tag, ":stall_term"}, t, st);
        check({tag, ":stall_idx"}, 64'(ix), 64'(six));
      end
      stalled = 1'b0;
      if (v) begin
        if (first_k < 0) first_k = k;
        if (rdy) begin
          if (exp_t.size() == 0) begin
            check({tag, ":extra_beat"}, t, 64'(exp_t.size()) + 64'hFFFF_0000_0000);
          end else begin
            check({tag, ":term"}, t, exp_t.pop_front());
            check({tag, ":idx"}, 64'(ix), 64'(exp_i.pop_front()));
          end
        end else begin
          stalled = 1'b1; st = t; six = ix;
        end
      end
    end
    drive(sel, 1'b0, lim, md, 1'b1);
    check({tag, ":done_seen"}, 64'(done_k >= 0), 64'd1);
    if (done_k >= 0) begin
      check({tag, ":missing_beats"}, 64'(exp_t.size()), 64'd0);
      check({tag, ":overflow"}, 64'(o), 64'(exp_ovf));
      if (!rnd) begin
        check({tag, ":done_latency"}, 64'(done_k), 64'(exp_nterms + 2));
        if (had_beats) check({tag, ":first_latency"}, 64'(first_k), 64'(first_idx + 1));
      end
      @(negedge clk);
      sample(sel, v, d, o, t, ix);
      check({tag, ":done_pulse"}, 64'(d), 64'd0);
    end
  endtask

  task automatic check_zero(input bit sel, input string tag);
    bit v, d, o;
    logic [63:0] t;
    int unsigned ix;
    sample(sel, v, d, o, t, ix);
    check({tag, ":valid"}, 64'(v), 64'd0);
    check({tag, ":done"}, 64'(d), 64'd0);
    check({tag, ":overflow"}, 64'(o), 64'd0);
    check({tag, ":term"}, t, 64'd0);
    check({tag, ":idx"}, 64'(ix), 64'd0);
  endtask

  initial begin
    int waited;
    drive(1'b0, 1'b0, 32'd0, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 2'd0, 1'b1);
    repeat (3) @(negedge clk);
    check_zero(1'b0, "reset32");
    check_zero(1'b1, "reset8");
    rst_n = 1'b1;

    run(1'b0, 32'd10,  MODE_ALL,  1'b0, 1'b0, "all10");
    run(1'b0, 32'd100, MODE_EVEN, 1'b0, 1'b0, "even100");
    run(1'b0, 32'd10,  MODE_ODD,  1'b0, 1'b0, "odd10");
    run(1'b0, 32'd0,   MODE_ALL,  1'b0, 1'b0, "n0");
    run(1'b0, 32'hFFFF_FFFF, 2'd3, 1'b0, 1'b0, "max32");
    run(1'b1, 32'd255, MODE_ALL,  1'b0, 1'b0, "ovf8");
    run(1'b1, 32'd50,  MODE_ALL,  1'b0, 1'b0, "after_ovf8");
    run(1'b0, 32'd1000, MODE_ALL, 1'b1, 1'b1, "stall1000");
    for (int r = 0; r < 6; r++) begin
      run(1'b0, (r % 2 == 0) ? $urandom : $urandom_range(0, 5000),
          2'($urandom_range(0, 3)), 1'b1, 1'b1, "rand32");
      run(1'b1, 32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'b1, 1'b1, "rand8");
    end

    // Abort a run while a beat is stalled.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd1000, MODE_ALL, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd1000, MODE_ALL, 1'b0);
    waited = 0;
    while (!i32.__valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("abort:valid_before_reset", 64'(i32.__valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_zero(1'b0, "abort");
    repeat (3) @(negedge clk);
    check_zero(1'b0, "abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check("abort:no_done", 64'(i32.__done), 64'd0);
    run(1'b0, 32'd10, MODE_ALL, 1'b0, 1'b0, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
